// File: rtl/usb_keyboard_report_gen.sv
// USB-HID boot-keyboard IN report generator: queues key presses and serves each
// as a press report followed by an all-zero release report, advancing only on ACK.
module usb_keyboard_report_gen #(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        key_value,
  input  logic               key_request,
  output logic               key_drop,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic               in_start,
  output logic               in_nak,
  output logic               in_valid,
  output logic [7:0]         in_data,
  output logic               in_last,
  input  logic               in_ready,
  input  logic               in_ack
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_WACK = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd0, PH_PRESS = 2'd1, PH_REL = 2'd2;

  logic [15:0]        mem_q [DEPTH];
  logic [15:0]        mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [1:0]         state_q, state_d, phase_q, phase_d;
  logic [2:0]         idx_q, idx_d;
  logic [63:0]        latch_q, latch_d;
  logic               nak_q, nak_d, drop_q, drop_d;
  logic               push, pop, empty, full;
  logic [15:0]        head;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);
  assign head  = mem_q[rd_ptr_q];
  // The pop happens on the ACK of a press report; it frees a slot for a same-cycle push.
  assign pop   = (state_q == S_WACK) && in_ack && (phase_q == PH_PRESS);
  assign push  = key_request && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    latch_d  = latch_q;
    nak_d    = 1'b0;
    drop_d   = key_request && !push;

    if (push) begin
      mem_d[wr_ptr_q] = key_value;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push && !pop)      level_d = level_q + (FIFO_AW+1)'(1);
    else if (pop && !push) level_d = level_q - (FIFO_AW+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          if (phase_q == PH_NONE) begin
            if (empty) nak_d = 1'b1;
            else begin
              // Byte 0 sits in the low byte: modifier, reserved, keycode, zeros.
              latch_d = {40'h0, head[7:0], 8'h00, head[15:8]};
              phase_d = PH_PRESS;
              state_d = S_SEND;
              idx_d   = 3'd0;
            end
          end else begin
            state_d = S_SEND;
            idx_d   = 3'd0;
          end
        end
      end
      S_SEND: begin
        if (in_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_WACK;
        end
      end
      S_WACK: begin
        if (in_ack) begin
          state_d = S_IDLE;
          if (phase_q == PH_PRESS) begin
            latch_d = 64'h0;
            phase_d = PH_REL;
          end else begin
            phase_d = PH_NONE;
          end
        end else if (in_start) begin
          state_d = S_SEND;
          idx_d   = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      phase_q  <= PH_NONE;
      idx_q    <= 3'd0;
      latch_q  <= 64'h0;
      nak_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
      nak_q    <= nak_d;
      drop_q   <= drop_d;
    end
  end

  assign in_valid   = (state_q == S_SEND);
  assign in_data    = in_valid ? latch_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign in_last    = in_valid && (idx_q == 3'd7);
  assign in_nak     = nak_q;
  assign key_drop   = drop_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_usb_keyboard_report_gen.sv
// Randomized self-checking bench: a key queue plus pending-report model predicts
// every report, NAK, drop and queue level.
module tb_usb_keyboard_report_gen;
  localparam int FIFO_AW = 2;
  localparam int DEPTH = 1 << FIFO_AW;

  logic clk = 0, rst = 1;
  logic [15:0] key_value = 0;
  logic key_request = 0, key_drop, in_start = 0, in_nak, in_valid, in_last;
  logic in_ready = 0, in_ack = 0;
  logic [7:0] in_data;
  logic [FIFO_AW:0] fifo_level;

  int n_cmp = 0, n_bad = 0;

  // Model: keys waiting, and which report the host still owes an ACK for.
  logic [15:0] mq[$];
  int pend = 0;  // 0 nothing, 1 press of mq[0], 2 release

  usb_keyboard_report_gen #(.FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_request(key_request),
    .key_drop(key_drop), .fifo_level(fifo_level), .in_start(in_start),
    .in_nak(in_nak), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .in_ack(in_ack));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] press_rep(logic [15:0] k);
    logic [63:0] r;
    r = 64'h0;
    r[7:0]   = k[15:8];
    r[23:16] = k[7:0];
    return r;
  endfunction

  function automatic logic [63:0] model_next_report();
    if (pend == 0) pend = 1;
    return (pend == 1) ? press_rep(mq[0]) : 64'h0;
  endfunction

  task automatic push(input logic [15:0] k);
    key_request = 1; key_value = k; tick; key_request = 0;
  endtask

  task automatic start_only;
    in_start = 1; tick; in_start = 0;
  endtask

  task automatic get_report(input bit bp, output logic [63:0] rep, output int n,
                            output int cyc, output bit last_ok, output bit stable_ok);
    logic [7:0] held;
    bit holding, rdy;
    rep = 0; n = 0; last_ok = 1; stable_ok = 1; holding = 0; held = 0;
    start_only;
    for (cyc = 0; cyc < 40 && n < 8; cyc++) begin
      rdy = bp ? cyc[0] : 1'b1;
      if (in_valid) begin
        if (holding && in_data !== held) stable_ok = 0;
        if (in_last !== (n == 7)) last_ok = 0;
        if (rdy) begin rep[n*8 +: 8] = in_data; n++; holding = 0; end
        else begin holding = 1; held = in_data; end
      end else if (holding) stable_ok = 0;
      in_ready = rdy;
      tick;
    end
    in_ready = 0;
  endtask

  task automatic ack(input bit with_push, input logic [15:0] k);
    in_ack = 1; key_request = with_push; key_value = k; tick;
    in_ack = 0; key_request = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick; tick; rst = 0;
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", in_valid); end
    n_cmp++; if (in_nak !== 1'b0) begin n_bad++; $display("FAIL reset_nak got %b want 0", in_nak); end
    n_cmp++; if (in_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", in_last); end
    n_cmp++; if (in_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", in_data); end
    n_cmp++; if (fifo_level !== '0) begin n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if (key_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got %b want 0", key_drop); end
    mq.delete(); pend = 0;
  endtask

  task automatic test_nak;
    start_only;
    n_cmp++; if (in_nak !== 1'b1) begin n_bad++; $display("FAIL nak_pulse got %b want 1", in_nak); end
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL nak_valid got %b want 0", in_valid); end
    tick;
    n_cmp++; if (in_nak !== 1'b0) begin n_bad++; $display("FAIL nak_width got %b want 0", in_nak); end
  endtask

  task automatic test_basic;
    logic [63:0] rep; int n, cyc; bit lok, sok;
    push(16'h0204); mq.push_back(16'h0204);
    n_cmp++; if (fifo_level !== 1) begin n_bad++; $display("FAIL basic_level got %0d want 1", fifo_level); end
    get_report(0, rep, n, cyc, lok, sok);
    n_cmp++; if (rep !== 64'h0000_0000_0004_0002) begin n_bad++; $display("FAIL basic_press got %h want 0000000000040002", rep); end
    n_cmp++; if (cyc !== 8 || n !== 8) begin n_bad++; $display("FAIL basic_stream got %0d cycles %0d bytes want 8/8", cyc, n); end
    n_cmp++; if (lok !== 1'b1) begin n_bad++; $display("FAIL basic_last got %b want 1", lok); end
    ack(0, 0); void'(mq.pop_front()); pend = 2;
    n_cmp++; if (fifo_level !== 0) begin n_bad++; $display("FAIL basic_pop got %0d want 0", fifo_level); end
    get_report(0, rep, n, cyc, lok, sok);
    n_cmp++; if (rep !== 64'h0 || n !== 8) begin n_bad++; $display("FAIL basic_release got %h (%0d bytes) want 0", rep, n); end
    ack(0, 0); pend = 0;
    start_only;
    n_cmp++; if (in_nak !== 1'b1) begin n_bad++; $display("FAIL basic_nak got %b want 1", in_nak); end
    tick;
  endtask

  task automatic test_resend;
    logic [63:0] rep, exp; int n, cyc; bit lok, sok;
    logic [15:0] k;
    k = 16'($urandom); push(k); mq.push_back(k);
    exp = model_next_report();
    get_report(0, rep, n, cyc, lok, sok);
    n_cmp++; if (rep !== exp) begin n_bad++; $display("FAIL resend_first got %h want %h", rep, exp); end
    get_report(0, rep, n, cyc, lok, sok);
    n_cmp++; if (rep !== exp || n !== 8) begin n_bad++; $display("FAIL resend_again got %h want %h", rep, exp); end
    n_cmp++; if (fifo_level !== 1) begin n_bad++; $display("FAIL resend_level got %0d want 1", fifo_level); end
    ack(0, 0); void'(mq.pop_front()); pend = 2;
    n_cmp++; if (fifo_level !== 0) begin n_bad++; $display("FAIL resend_pop got %0d want 0", fifo_level); end
    get_report(0, rep, n, cyc, lok, sok);
    ack(0, 0); pend = 0;
  endtask

  task automatic test_backpressure;
    logic [63:0] rep, exp; int n, cyc; bit lok, sok;
    logic [15:0] k;
    k = 16'($urandom); push(k); mq.push_back(k);
    for (int r = 0; r < 2; r++) begin
      exp = model_next_report();
      get_report(1, rep, n, cyc, lok, sok);
      n_cmp++; if (rep !== exp || n !== 8) begin n_bad++; $display("FAIL bp_bytes got %h (%0d) want %h", rep, n, exp); end
      n_cmp++; if (sok !== 1'b1 || lok !== 1'b1) begin n_bad++; $display("FAIL bp_stable got stable=%b last=%b want 1/1", sok, lok); end
      ack(0, 0);
      if (pend == 1) begin void'(mq.pop_front()); pend = 2; end else pend = 0;
    end
  endtask

  task automatic test_overflow;
    logic [63:0] rep, exp; int n, cyc, drops; bit lok, sok;
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      push(16'(4 + i));
      if (mq.size() < DEPTH) mq.push_back(16'(4 + i));
      if (key_drop === 1'b1) drops++;
    end
    tick;
    if (key_drop === 1'b1) drops++;
    n_cmp++; if (fifo_level !== 4) begin n_bad++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    n_cmp++; if (drops !== 1) begin n_bad++; $display("FAIL ovf_drops got %0d want 1", drops); end
    while (mq.size() > 0 || pend != 0) begin
      exp = model_next_report();
      get_report(0, rep, n, cyc, lok, sok);
      n_cmp++; if (rep !== exp) begin n_bad++; $display("FAIL ovf_report got %h want %h", rep, exp); end
      ack(0, 0);
      if (pend == 1) begin void'(mq.pop_front()); pend = 2; end else pend = 0;
    end
    start_only;
    n_cmp++; if (in_nak !== 1'b1) begin n_bad++; $display("FAIL ovf_nak got %b want 1 (key 0008 served?)", in_nak); end
    tick;
  endtask

  task automatic test_random;
    logic [63:0] rep, exp; int n, cyc; bit lok, sok, wp, exp_drop;
    logic [15:0] k;
    for (int it = 0; it < 40; it++) begin
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        k = 16'($urandom);
        exp_drop = (mq.size() >= DEPTH);
        push(k);
        if (!exp_drop) mq.push_back(k);
        n_cmp++; if (key_drop !== exp_drop || fifo_level !== 3'(mq.size()))
          begin n_bad++; $display("FAIL rnd_push drop=%b lvl=%0d want %b/%0d", key_drop, fifo_level, exp_drop, mq.size()); end
      end
      if (pend == 0 && mq.size() == 0) begin
        start_only;
        n_cmp++; if (in_nak !== 1'b1 || in_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_nak got %b want 1", in_nak); end
        tick;
        continue;
      end
      exp = model_next_report();
      get_report($urandom_range(0, 1), rep, n, cyc, lok, sok);
      n_cmp++; if (rep !== exp || n !== 8 || !lok || !sok)
        begin n_bad++; $display("FAIL rnd_report got %h n=%0d l=%b s=%b want %h", rep, n, lok, sok, exp); end
      if ($urandom_range(0, 2) == 0) begin
        get_report(0, rep, n, cyc, lok, sok);
        n_cmp++; if (rep !== exp) begin n_bad++; $display("FAIL rnd_retry got %h want %h", rep, exp); end
      end
      wp = $urandom_range(0, 1); k = 16'($urandom);
      ack(wp, k);
      if (pend == 1) begin void'(mq.pop_front()); pend = 2; end else pend = 0;
      exp_drop = wp && (mq.size() >= DEPTH);
      if (wp && !exp_drop) mq.push_back(k);
      n_cmp++; if (key_drop !== exp_drop || fifo_level !== 3'(mq.size()))
        begin n_bad++; $display("FAIL rnd_ack drop=%b lvl=%0d want %b/%0d", key_drop, fifo_level, exp_drop, mq.size()); end
    end
  endtask

  task automatic test_reset_mid;
    push(16'h0115); mq.push_back(16'h0115);
    start_only;
    in_ready = 1; tick; tick; tick;
    n_cmp++; if (in_valid !== 1'b1) begin n_bad++; $display("FAIL mid_before got %b want 1", in_valid); end
    rst = 1; tick; rst = 0; in_ready = 0;
    mq.delete(); pend = 0;
    n_cmp++; if (in_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", in_valid); end
    n_cmp++; if (fifo_level !== 0) begin n_bad++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    start_only;
    n_cmp++; if (in_nak !== 1'b1) begin n_bad++; $display("FAIL mid_nak got %b want 1", in_nak); end
    tick;
  endtask

  initial begin
    #1;
    test_reset;
    test_nak;
    test_basic;
    test_resend;
    test_backpressure;
    test_overflow;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_keyboard_report_gen.md
# usb_keyboard_report_gen

Converts keyboard press requests into USB-HID boot-keyboard IN reports inside the USB keyboard device. Upstream application logic issues one-cycle `key_request` pulses carrying a 16-bit `key_value`; this block queues them in a small FIFO. When the endpoint engine signals an IN transaction for the keyboard endpoint, the block serves an 8-byte report as a byte stream. Each queued key yields exactly two reports: a press report, then an all-zero release report. Each report is advanced only after the host ACKs it.

## Interface
Parameters:
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `clk`  in  1  device core clock (60 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `key_value`  in  16  [15:8] modifier byte, [7:0] keycode; sampled when `key_request`=1.
- `key_request`  in  1  one-cycle push request.
- `key_drop`  out  1  one-cycle pulse, 1 cycle after a `key_request` that was discarded because the FIFO was full.
- `fifo_level`  out  FIFO_AW+1  number of queued keys.
- `in_start`  in  1  one-cycle pulse: host IN token addressed to the keyboard endpoint.
- `in_nak`  out  1  one-cycle pulse: nothing to send for this token.
- `in_valid`  out  1  report byte valid.
- `in_data`  out  8  report byte.
- `in_last`  out  1  marks byte 7 of the report; qualified by `in_valid`.
- `in_ready`  in  1  byte accepted when `in_valid` & `in_ready`.
- `in_ack`  in  1  one-cycle pulse: host ACKed the last report.

## Operation
- FIFO:
  - Push on `key_request` if not full. If full, discard the request and pulse `key_drop`.
  - Pop only on an `in_ack` that completes a press report.
  - Push and pop in the same cycle are both performed, and a push while full is accepted if a pop happens in that cycle. `fifo_level` is unchanged in either case.
  - Keycode 0x00 is queued normally; this gives a modifier-only press.
- Phase register: NONE / PRESS / RELEASE. Report latch: 8 bytes.
  - PRESS report: byte0 = modifier, byte1 = 0x00, byte2 = keycode, bytes 3..7 = 0x00. Built from the FIFO head, which is not popped when the report is built.
  - RELEASE report: all eight bytes 0x00.
- States: IDLE, SEND, WAIT_ACK.
- From IDLE, on `in_start`:
  - phase NONE and FIFO empty: pulse `in_nak` and stay in IDLE.
  - phase NONE and FIFO non-empty: latch the PRESS report, set phase = PRESS, go to SEND with idx = 0.
  - phase PRESS or RELEASE (a report is pending after a missed ACK): go to SEND with idx = 0 and the latch unchanged.
- SEND:
  - `in_valid` = 1 and `in_data` = latch[idx].
  - Each handshake increments idx.
  - `in_last` = (idx == 7).
  - The handshake on idx 7 moves the block to WAIT_ACK.
  - `in_start` in SEND is ignored.
- WAIT_ACK:
  - `in_ack` with phase PRESS: pop the FIFO, latch the RELEASE report, set phase = RELEASE, go to IDLE.
  - `in_ack` with phase RELEASE: set phase = NONE, go to IDLE.
  - `in_start` (host retry, no ACK seen): go to SEND with idx = 0, resending the same report.
  - If `in_ack` and `in_start` arrive in the same cycle, `in_ack` wins and `in_start` is dropped.
- `in_ack` outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - Outputs: `key_drop`, `in_nak`, `in_valid`, `in_last`, `in_data`, `fifo_level` all 0.
  - Internal: FIFO empty, phase NONE, state IDLE.
- Reset mid-transfer: `in_valid` is 0 in the cycle after `rst`, and all queued keys are lost.
- `key_request` → `fifo_level` increments the next cycle.
- `in_start` → `in_valid` (byte 0) or `in_nak` the next cycle.
- With `in_ready` held at 1, the report streams in 8 consecutive cycles.
- `in_valid` stays high, with `in_data` stable, while `in_ready` = 0.
- Last handshake → WAIT_ACK the next cycle. `in_ack` → IDLE the next cycle.
- The pop on ACK is visible in `fifo_level` the cycle after `in_ack`.

## Test plan
- Empty queue: `in_start` → `in_nak` = 1 for one cycle, `in_valid` stays 0.
- Push `key_value` = 0x0204, then `in_start` with `in_ready` = 1 → bytes 02,00,04,00,00,00,00,00 with `in_last` on the 8th. `in_ack`, then `in_start` → 8 × 0x00. `in_ack`, then `in_start` → `in_nak`.
- Resend: after the press report, issue `in_start` without `in_ack` → identical report resent, `fifo_level` still 1. Then `in_ack` → level 0.
- Back-pressure: toggle `in_ready` every other cycle → each byte is held stable until accepted, and 8 bytes are delivered in order.
- Overflow with FIFO_AW = 2: push 5 keys 0x0004..0x0008 → `fifo_level` = 4, `key_drop` pulses once, and the 0x0008 key is never reported.
- Reset asserted during byte 3 of SEND → `in_valid` = 0 the next cycle. After release, `in_start` → `in_nak`.
